// File: rtl/ex_hazard_controller_if.sv
// Execute-stage hazard controller bundle: ID decode fields and EX check in,
// forwarding selects, stall/flush enables and debug state out.
interface ex_hazard_controller_if #(
  parameter int REG_ADDR_W = 5
);
  // No valid/ready handshake here. id_valid_i qualifies every id_* field in
  // the same cycle, ex_isValid_i is sampled every RUN/STALL cycle, and the
  // outputs are level signals that the pipeline obeys on the next clk edge.
  logic                  id_valid_i;
  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic                  id_use_rs1_i;
  logic                  id_use_rs2_i;
  logic [REG_ADDR_W-1:0] id_rd_i;
  logic                  id_we_i;
  logic                  id_is_load_i;
  logic                  ex_isValid_i;
  logic [1:0]            A_sel_o;
  logic [1:0]            B_sel_o;
  logic                  stall_o;
  logic                  flush_o;
  logic [1:0]            state_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    output id_rd_i, id_we_i, id_is_load_i, ex_isValid_i,
    input  A_sel_o, B_sel_o, stall_o, flush_o, state_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
    input  id_rd_i, id_we_i, id_is_load_i, ex_isValid_i,
    output A_sel_o, B_sel_o, stall_o, flush_o, state_o
  );
endinterface

// File: rtl/ex_hazard_controller.sv
// Execute-stage hazard controller: shadows EX/MEM destinations, registers
// operand forwarding selects, inserts load-use stalls and sequences flushes.
module ex_hazard_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  ex_hazard_controller_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_e;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_we_q, ex_we_d;
  logic                  ex_ld_q, ex_ld_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_we_q, mem_we_d;
  logic [1:0]            a_sel_q, a_sel_d;
  logic [1:0]            b_sel_q, b_sel_d;

  logic ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
  logic load_use, mispredict;
  logic stall_c, flush_c, advance_c;

  // Register 0 is never a producer: rs==0 never matches, and ex_we is
  // stored cleared when rd==0.
  always_comb begin
    ex_hit_rs1  = hz.id_use_rs1_i && (hz.id_rs1_i != '0) && ex_we_q  && (ex_rd_q  == hz.id_rs1_i);
    ex_hit_rs2  = hz.id_use_rs2_i && (hz.id_rs2_i != '0) && ex_we_q  && (ex_rd_q  == hz.id_rs2_i);
    mem_hit_rs1 = hz.id_use_rs1_i && (hz.id_rs1_i != '0) && mem_we_q && (mem_rd_q == hz.id_rs1_i);
    mem_hit_rs2 = hz.id_use_rs2_i && (hz.id_rs2_i != '0) && mem_we_q && (mem_rd_q == hz.id_rs2_i);
    load_use    = hz.id_valid_i && ex_ld_q && (ex_hit_rs1 || ex_hit_rs2);
    mispredict  = !hz.ex_isValid_i;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LAST;
        end else if (load_use) begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        if (mispredict) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LAST;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Output logic. A mispredict beats a load-use hazard, and the instruction
  // in ID at that moment is wrong-path, so it never enters the shadow.
  always_comb begin
    stall_c   = 1'b0;
    flush_c   = 1'b0;
    advance_c = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        stall_c   = !mispredict && load_use;
        advance_c = !mispredict && !load_use && hz.id_valid_i;
      end
      ST_STALL: begin
        advance_c = !mispredict && hz.id_valid_i;
      end
      ST_FLUSH: begin
        flush_c = 1'b1;
      end
      default: begin
        stall_c = 1'b0;
      end
    endcase
  end

  // Shadow pipeline and forwarding selects for the instruction entering EX.
  always_comb begin
    ex_rd_d  = advance_c ? hz.id_rd_i : '0;
    ex_we_d  = advance_c && hz.id_we_i && (hz.id_rd_i != '0);
    ex_ld_d  = advance_c && hz.id_is_load_i;
    mem_rd_d = ex_rd_q;
    mem_we_d = ex_we_q;
    a_sel_d  = SEL_REG;
    b_sel_d  = SEL_REG;
    if (advance_c) begin
      if (ex_hit_rs1 && !ex_ld_q) begin
        a_sel_d = SEL_MEM;
      end else if (mem_hit_rs1) begin
        a_sel_d = SEL_WB;
      end
      if (ex_hit_rs2 && !ex_ld_q) begin
        b_sel_d = SEL_MEM;
      end else if (mem_hit_rs2) begin
        b_sel_d = SEL_WB;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      cnt_q    <= 2'd0;
      ex_rd_q  <= '0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_we_q <= 1'b0;
      a_sel_q  <= SEL_REG;
      b_sel_q  <= SEL_REG;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ex_rd_q  <= ex_rd_d;
      ex_we_q  <= ex_we_d;
      ex_ld_q  <= ex_ld_d;
      mem_rd_q <= mem_rd_d;
      mem_we_q <= mem_we_d;
      a_sel_q  <= a_sel_d;
      b_sel_q  <= b_sel_d;
    end
  end

  assign hz.A_sel_o = a_sel_q;
  assign hz.B_sel_o = b_sel_q;
  assign hz.stall_o = stall_c;
  assign hz.flush_o = flush_c;
  assign hz.state_o = state_q;

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Bench for ex_hazard_controller: two instances (one- and three-cycle flush)
// driven in lockstep and checked every cycle against a behavioural model.
module tb_ex_hazard_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic       d_valid, d_use1, d_use2, d_we, d_ld, d_isvalid;
  logic [4:0] d_rs1, d_rs2, d_rd;

  ex_hazard_controller_if #(.REG_ADDR_W(5)) if1 ();
  ex_hazard_controller_if #(.REG_ADDR_W(5)) if3 ();

  assign if1.id_valid_i   = d_valid;
  assign if1.id_rs1_i     = d_rs1;
  assign if1.id_rs2_i     = d_rs2;
  assign if1.id_use_rs1_i = d_use1;
  assign if1.id_use_rs2_i = d_use2;
  assign if1.id_rd_i      = d_rd;
  assign if1.id_we_i      = d_we;
  assign if1.id_is_load_i = d_ld;
  assign if1.ex_isValid_i = d_isvalid;
  assign if3.id_valid_i   = d_valid;
  assign if3.id_rs1_i     = d_rs1;
  assign if3.id_rs2_i     = d_rs2;
  assign if3.id_use_rs1_i = d_use1;
  assign if3.id_use_rs2_i = d_use2;
  assign if3.id_rd_i      = d_rd;
  assign if3.id_we_i      = d_we;
  assign if3.id_is_load_i = d_ld;
  assign if3.ex_isValid_i = d_isvalid;

  ex_hazard_controller #(.REG_ADDR_W(5), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .hz(if1)
  );
  ex_hazard_controller #(.REG_ADDR_W(5), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .hz(if3)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  // Index 0 models the one-cycle-flush instance, index 1 the three-cycle one.
  typedef struct packed {
    logic       we;
    logic       ld;
    logic [4:0] rd;
  } slot_t;

  slot_t      m_ex [2];
  slot_t      m_mem[2];
  int         m_left[2];
  bit         m_stalled[2];
  logic [1:0] m_a[2];
  logic [1:0] m_b[2];

  function automatic int fc_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit hits(slot_t s, logic u, logic [4:0] rs);
    return u && (rs != 5'd0) && s.we && (s.rd == rs);
  endfunction

  function automatic logic [1:0] fwd(slot_t e, slot_t m, logic u, logic [4:0] rs);
    if (hits(e, u, rs) && !e.ld) return 2'b01;
    if (hits(m, u, rs)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit model_lu(int i);
    return d_valid && m_ex[i].ld && (hits(m_ex[i], d_use1, d_rs1) || hits(m_ex[i], d_use2, d_rs2));
  endfunction

  function automatic bit exp_flush(int i);
    return m_left[i] > 0;
  endfunction

  function automatic bit exp_stall(int i);
    return !exp_flush(i) && d_isvalid && model_lu(i);
  endfunction

  function automatic logic [1:0] exp_state(int i);
    if (exp_flush(i)) return 2'b10;
    if (m_stalled[i]) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ex[i] = '0;
      m_mem[i] = '0;
      m_left[i] = 0;
      m_stalled[i] = 1'b0;
      m_a[i] = 2'b00;
      m_b[i] = 2'b00;
    end
  endtask

  task automatic model_advance();
    for (int i = 0; i < 2; i++) begin
      slot_t      nx;
      logic [1:0] na, nb;
      bit         lu;
      nx = '0;
      na = 2'b00;
      nb = 2'b00;
      lu = model_lu(i);
      if (m_left[i] > 0) begin
        m_left[i]--;
        m_stalled[i] = 1'b0;
      end else if (!d_isvalid) begin
        m_left[i] = fc_of(i);
        m_stalled[i] = 1'b0;
      end else if (lu) begin
        m_stalled[i] = 1'b1;
      end else begin
        m_stalled[i] = 1'b0;
        if (d_valid) begin
          nx = {d_we, d_ld, d_rd};
          na = fwd(m_ex[i], m_mem[i], d_use1, d_rs1);
          nb = fwd(m_ex[i], m_mem[i], d_use2, d_rs2);
        end
      end
      m_mem[i] = m_ex[i];
      m_ex[i]  = nx;
      m_a[i]   = na;
      m_b[i]   = nb;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic cmp(string nm, int i, logic [1:0] a, logic [1:0] b,
                     logic s, logic f, logic [1:0] st);
    if (a !== m_a[i]) begin
      miscompares++;
      $display("FAIL %s A_sel t=%0t got %b want %b", nm, $time, a, m_a[i]);
    end
    if (b !== m_b[i]) begin
      miscompares++;
      $display("FAIL %s B_sel t=%0t got %b want %b", nm, $time, b, m_b[i]);
    end
    if (s !== exp_stall(i)) begin
      miscompares++;
      $display("FAIL %s stall t=%0t got %b want %b", nm, $time, s, exp_stall(i));
    end
    if (f !== exp_flush(i)) begin
      miscompares++;
      $display("FAIL %s flush t=%0t got %b want %b", nm, $time, f, exp_flush(i));
    end
    if (st !== exp_state(i)) begin
      miscompares++;
      $display("FAIL %s state t=%0t got %b want %b", nm, $time, st, exp_state(i));
    end
  endtask

  task automatic lit2(string nm, logic [1:0] act, logic [1:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic lit1(string nm, logic act, logic exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Compare at the falling edge, advance the model at the rising edge,
  // return 1 time unit after it so callers can drive the next inputs.
  task automatic step();
    @(negedge clk);
    vectors++;
    cmp("dut1", 0, if1.A_sel_o, if1.B_sel_o, if1.stall_o, if1.flush_o, if1.state_o);
    cmp("dut3", 1, if3.A_sel_o, if3.B_sel_o, if3.stall_o, if3.flush_o, if3.state_o);
    @(posedge clk);
    if (!reset) model_reset();
    else model_advance();
    #1;
  endtask

  task automatic set_id(logic v, logic [4:0] r1, logic [4:0] r2, logic u1, logic u2,
                        logic [4:0] rd, logic we, logic ld);
    d_valid = v;
    d_rs1 = r1;
    d_rs2 = r2;
    d_use1 = u1;
    d_use2 = u2;
    d_rd = rd;
    d_we = we;
    d_ld = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    d_isvalid = 1'b1;
  endtask

  task automatic rand_inputs();
    d_valid   = ($urandom_range(0, 9) < 8);
    d_rs1     = 5'($urandom_range(0, 3));
    d_rs2     = 5'($urandom_range(0, 3));
    d_use1    = 1'($urandom_range(0, 1));
    d_use2    = 1'($urandom_range(0, 1));
    d_rd      = 5'($urandom_range(0, 3));
    d_we      = ($urandom_range(0, 3) != 0);
    d_ld      = ($urandom_range(0, 2) == 0);
    d_isvalid = ($urandom_range(0, 11) != 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0;
    idle();
    model_reset();

    // Reset held with random inputs: everything stays zero.
    repeat (4) begin
      rand_inputs();
      #1;
      lit1("rst_stall1", if1.stall_o, 1'b0);
      lit1("rst_flush3", if3.flush_o, 1'b0);
      lit2("rst_state1", if1.state_o, 2'b00);
      lit2("rst_asel3", if3.A_sel_o, 2'b00);
      step();
    end
    idle();
    reset = 1'b1;
    step();

    // ALU forwarding: producer rd=5, consumers via rs1 then rs2.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    lit2("alu_fwd_a", if1.A_sel_o, 2'b01);
    lit2("alu_fwd_b", if1.B_sel_o, 2'b00);
    set_id(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    step();
    lit2("wb_fwd_b", if1.B_sel_o, 2'b10);
    lit2("wb_fwd_a", if1.A_sel_o, 2'b00);

    // Load-use on rs2.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    lit1("lu_stall1", if1.stall_o, 1'b1);
    lit1("lu_stall3", if3.stall_o, 1'b1);
    step();
    lit2("lu_state", if1.state_o, 2'b01);
    #1;
    lit1("lu_no_second", if1.stall_o, 1'b0);
    step();
    lit2("lu_fwd_b", if1.B_sel_o, 2'b10);
    lit2("lu_back_run", if1.state_o, 2'b00);

    // Load into rd=0 never stalls.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    lit1("r0_no_stall", if1.stall_o, 1'b0);
    step();
    lit2("r0_sel_b", if1.B_sel_o, 2'b00);

    // Mispredict in RUN.
    idle();
    d_isvalid = 1'b0;
    step();
    d_isvalid = 1'b1;
    lit1("mp_flush1", if1.flush_o, 1'b1);
    lit2("mp_state1", if1.state_o, 2'b10);
    lit1("mp_flush3", if3.flush_o, 1'b1);
    lit2("mp_sel3", if3.A_sel_o, 2'b00);
    step();
    lit1("mp_end1", if1.flush_o, 1'b0);
    lit1("mp_mid3a", if3.flush_o, 1'b1);
    step();
    lit1("mp_mid3b", if3.flush_o, 1'b1);
    step();
    lit1("mp_end3", if3.flush_o, 1'b0);
    lit2("mp_run3", if3.state_o, 2'b00);

    // Mispredict during STALL.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    step();
    d_isvalid = 1'b0;
    #1;
    lit2("st_mp_state", if1.state_o, 2'b01);
    step();
    idle();
    lit1("st_mp_flush", if1.flush_o, 1'b1);
    lit1("st_mp_nostall", if1.stall_o, 1'b0);
    repeat (3) step();

    // Mispredict coinciding with load-use: no stall, flush wins.
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    d_isvalid = 1'b0;
    #1;
    lit1("co_nostall1", if1.stall_o, 1'b0);
    lit1("co_nostall3", if3.stall_o, 1'b0);
    step();
    idle();
    lit1("co_flush3", if3.flush_o, 1'b1);
    lit2("co_state3", if3.state_o, 2'b10);
    repeat (3) step();

    // Asynchronous reset in the middle of a three-cycle flush.
    d_isvalid = 1'b0;
    step();
    d_isvalid = 1'b1;
    step();
    lit1("rmf_flush3", if3.flush_o, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    lit1("rmf_cleared", if3.flush_o, 1'b0);
    lit2("rmf_state3", if3.state_o, 2'b00);
    lit2("rmf_state1", if1.state_o, 2'b00);
    model_reset();
    repeat (2) step();
    reset = 1'b1;
    step();
    lit2("rmf_run", if3.state_o, 2'b00);

    // Randomized traffic.
    repeat (3000) begin
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_hazard_controller.md
Name: ex_hazard_controller

Overview:
- Sequences the execute stage.
- Tracks destination registers of in-flight instructions and generates registered forwarding selects (A_sel/B_sel) for the instruction entering EX.
- Inserts load-use stalls.
- Runs a flush sequence when EX reports a branch mispredict (isValid low).
- Sits beside the ID/EX pipeline register; drives its stall/flush enables and the EX operand muxes.

Parameters:
REG_ADDR_W, 5, register index width
FLUSH_CYCLES, 1, cycles flush_o stays high after a mispredict (1..3)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset
id_valid_i  input  1  ID holds a real instruction
id_rs1_i  input  5  ID source 1 index
id_rs2_i  input  5  ID source 2 index
id_use_rs1_i  input  1  ID instruction reads rs1
id_use_rs2_i  input  1  ID instruction reads rs2
id_rd_i  input  5  ID destination index
id_we_i  input  1  ID instruction writes rd
id_is_load_i  input  1  ID instruction is a load
ex_isValid_i  input  1  EX prediction check; 0 = mispredict
A_sel_o  output  2  EX operand A select: 00 A_i, 01 Data_MEM, 10 Data_WB
B_sel_o  output  2  EX operand B select, same encoding
stall_o  output  1  hold PC and IF/ID, insert bubble into ID/EX
flush_o  output  1  squash IF/ID and ID/EX contents
state_o  output  2  FSM state (debug): 00 RUN, 01 STALL, 10 FLUSH

Behaviour:
Interface and reset:
- One clock, clk.
- reset is asynchronous, active-low.
- While reset=0: FSM=RUN; all tracking regs cleared (ex_/mem_ rd=0, we=0, ld=0); A_sel_o=B_sel_o=00; stall_o=0; flush_o=0; flush counter=0.
- Reset asserted mid-stall or mid-flush aborts the sequence immediately.

Internal tracking:
- Shadow pipeline ex_{rd,we,ld} -> mem_{rd,we}, shifted every cycle.
- ex_* loads from ID inputs when the ID instruction advances (RUN, no stall, id_valid_i=1); otherwise it loads a bubble (we=0).
- rd=0 is never a producer; treat its we as 0.

Hazard detection (combinational on ID inputs vs ex_*/mem_*):
- match_ex(rs): use && rs!=0 && ex_we && ex_rd==rs
- match_mem(rs): use && rs!=0 && mem_we && mem_rd==rs
- load_use = id_valid_i && ex_ld && (match_ex(rs1) || match_ex(rs2))

Forward selects (registered, valid one cycle later for the instruction then in EX), per operand:
- match_ex and not load -> 01 (producer will be in MEM)
- else match_mem -> 10 (producer will be in WB)
- else 00
- match_ex has priority over match_mem.
- Selects are registered only on advance; on stall or flush they load 00.

FSM:
- RUN:
  - if ex_isValid_i=0: go to FLUSH; flush_o=1 next cycle; counter=FLUSH_CYCLES-1.
  - else if load_use: go to STALL; stall_o=1 this cycle (combinational); bubble into ex_*.
  - else stay in RUN.
- STALL: exactly one cycle.
  - Load is now in mem_*, so the re-evaluated operand selects 10.
  - If ex_isValid_i=0: go to FLUSH.
  - Otherwise re-evaluate load_use (now false) and return to RUN, advancing the instruction.
- FLUSH: flush_o=1, stall_o=0, ex_* bubbled, selects 00.
  - While counter!=0: decrement.
  - When counter=0: return to RUN next cycle.
  - ex_isValid_i is ignored during FLUSH (its instruction is squashed).

Simultaneous events:
- Mispredict and load_use in the same cycle: mispredict wins, no stall.
- flush_o and stall_o are never both 1.

Latency:
- stall_o is combinational in the detecting cycle.
- flush_o asserts the cycle after the mispredict.
- Selects are one cycle after the ID decision.

Test Plan:
- Reset: reset=0 with random inputs -> all outputs 0 and state_o=00 until the first clk after release.
- ALU forwarding: cycle 0 ID rd=5 we=1; cycle 1 ID rs1=5 -> cycle 2 A_sel_o=01, B_sel_o=00. A third instruction with rs2=5 at cycle 2 -> cycle 3 B_sel_o=10.
- Load-use: load rd=7 then ID rs2=7 -> stall_o=1 for exactly one cycle, state_o=01. Next cycle B_sel_o=10, no second stall. Repeat with rd=0 -> no stall, selects 00.
- Mispredict: ex_isValid_i=0 in RUN -> flush_o=1 for FLUSH_CYCLES cycles (test 1 and 3), selects 00, then RUN.
- Mispredict during STALL, and mispredict coinciding with load_use -> FLUSH entered, stall_o=0 that cycle, never both high.
- Reset mid-flush (FLUSH_CYCLES=3, assert at counter=1) -> outputs cleared asynchronously, RUN after release.
